// File: rtl/counter8b_cmd_driver.sv
// Command-driven initiator for a counter8b-style counter.
// Turns LOAD / UP n / DOWN n / READ commands into per-cycle counter controls.
// It then reads back the counter, compares the result with its own expected value
// and returns the outcome on a valid/ready response channel.
module counter8b_cmd_driver #(
  parameter int WIDTH    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [7:0]       err_cnt,
  output logic             busy,
  // counter control interface
  output logic             ctr_ld_en,
  output logic             ctr_en,
  output logic             ctr_updwn,
  output logic [WIDTH-1:0] ctr_datain,
  input  logic [WIDTH-1:0] ctr_dataout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    SETTLE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_READ = 2'b11
  } op_t;

  state_t           state;
  state_t           state_d;
  op_t              cmd_kind;
  op_t              op_q;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] datain_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [7:0]       err_cnt_q;
  logic             mismatch;
  logic             is_step_op;

  assign cmd_kind   = op_t'(cmd_op);
  assign is_step_op = (cmd_kind == OP_UP) || (cmd_kind == OP_DOWN);

  // The counter result is only judged when checking is enabled; otherwise the error flag is constant 0.
  assign mismatch = CHECK_EN && (ctr_dataout != expected);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; commands and response ready only steer state, never outputs directly.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_kind == OP_LOAD) begin
            state_d = LOAD;
          end else if (is_step_op && (cmd_arg != '0)) begin
            state_d = STEP;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      LOAD:   state_d = SETTLE;
      STEP:   if (remaining == WIDTH'(1)) state_d = SETTLE;
      SETTLE: state_d = RESP;
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture and step counting; expected result is computed once at accept time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_LOAD;
      remaining <= '0;
      expected  <= '0;
      datain_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_kind;
            remaining <= cmd_arg;
            case (cmd_kind)
              OP_LOAD: begin
                expected <= cmd_arg;
                datain_q <= cmd_arg;
              end
              OP_UP:   expected <= ctr_dataout + cmd_arg;
              OP_DOWN: expected <= ctr_dataout - cmd_arg;
              default: expected <= ctr_dataout;
            endcase
          end
        end
        STEP:    remaining <= remaining - WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Response capture in SETTLE and the saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else if (state == SETTLE) begin
      rsp_data_q <= ctr_dataout;
      rsp_err_q  <= mismatch;
      if (mismatch && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Handshake and status outputs are pure state decode.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

  // Counter controls: load for one cycle in LOAD, step once per STEP cycle.
  // Direction is forced low outside STEP so idle controls read as all zero.
  assign ctr_ld_en  = (state == LOAD);
  assign ctr_en     = (state == STEP);
  assign ctr_updwn  = (state == STEP) && (op_q == OP_UP);
  assign ctr_datain = datain_q;

endmodule

// File: tb/tb_counter8b_cmd_driver.sv
// Bench for counter8b_cmd_driver.
// Two drivers run in lockstep: CHECK_EN=1 and CHECK_EN=0, each with its own counter model.
// A latency/timeline model of the command rules is checked on every cycle.
// Each directed command also pins data, latency and step count with literal values.
module tb_counter8b_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       rsp_ready;
  logic [7:0] fault_off;

  logic       cmd_ready [2];
  logic       rsp_valid [2];
  logic       rsp_err   [2];
  logic       busy      [2];
  logic       ctr_ld_en [2];
  logic       ctr_en    [2];
  logic       ctr_updwn [2];
  logic [7:0] rsp_data    [2];
  logic [7:0] err_cnt     [2];
  logic [7:0] ctr_datain  [2];
  logic [7:0] ctr_dataout [2];
  logic [7:0] ctr_q       [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  counter8b_cmd_driver #(.WIDTH(8), .CHECK_EN(1'b1)) dut_chk (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .err_cnt(err_cnt[0]), .busy(busy[0]),
    .ctr_ld_en(ctr_ld_en[0]), .ctr_en(ctr_en[0]), .ctr_updwn(ctr_updwn[0]),
    .ctr_datain(ctr_datain[0]), .ctr_dataout(ctr_dataout[0])
  );

  counter8b_cmd_driver #(.WIDTH(8), .CHECK_EN(1'b0)) dut_nochk (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .err_cnt(err_cnt[1]), .busy(busy[1]),
    .ctr_ld_en(ctr_ld_en[1]), .ctr_en(ctr_en[1]), .ctr_updwn(ctr_updwn[1]),
    .ctr_datain(ctr_datain[1]), .ctr_dataout(ctr_dataout[1])
  );

  // counter8b behaviour: sync reset to 0, load beats count, +/-1 mod 256; fault_off skews the readback
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)            ctr_q[i] <= 8'h00;
      else if (ctr_ld_en[i]) ctr_q[i] <= ctr_datain[i];
      else if (ctr_en[i])    ctr_q[i] <= ctr_updwn[i] ? ctr_q[i] + 8'd1 : ctr_q[i] - 8'd1;
    end
  end
  assign ctr_dataout[0] = ctr_q[0] + fault_off;
  assign ctr_dataout[1] = ctr_q[1] + fault_off;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // Cycle k counts from 1 in the cycle after the accept edge.
  // Rules: LOAD strobes ld_en in k=1 and first shows rsp_valid at k=3.
  // UP/DOWN n strobes en in k=1..n and first shows rsp_valid at k=n+2.
  // READ and n=0 first show rsp_valid at k=2.
  // The response holds until the cycle rsp_ready is high.
  bit         armed  = 1'b0;
  bit         active = 1'b0;
  int         k, m_lat, m_n;
  logic [1:0] m_op;
  logic [7:0] m_val, m_rsp, m_datain, base;
  logic       m_rerr;
  int         m_err;

  always @(negedge clk) begin
    if (armed) begin
      if (!active) begin
        check("idle_cmd_ready", cmd_ready[0], 1'b1);
        check("idle_busy",      busy[0],      1'b0);
        check("idle_rsp_valid", rsp_valid[0], 1'b0);
        check("idle_ld_en",     ctr_ld_en[0], 1'b0);
        check("idle_en",        ctr_en[0],    1'b0);
        check("idle_updwn",     ctr_updwn[0], 1'b0);
      end else begin
        check("act_cmd_ready",  cmd_ready[0], 1'b0);
        check("act_busy",       busy[0],      1'b1);
        check("act_ld_en",      ctr_ld_en[0], (m_op == 2'b00) && (k == 1));
        check("act_en",         ctr_en[0],    (m_op == 2'b01 || m_op == 2'b10) && (k <= m_n));
        check("act_updwn",      ctr_updwn[0], (m_op == 2'b01) && (k <= m_n));
        check("act_rsp_valid",  rsp_valid[0], k >= m_lat);
        check("nochk_rsp_valid", rsp_valid[1], k >= m_lat);
        check("nochk_en",       ctr_en[1],    (m_op == 2'b01 || m_op == 2'b10) && (k <= m_n));
      end
      check("rsp_data",       rsp_data[0],   m_rsp);
      check("rsp_err",        rsp_err[0],    m_rerr);
      check("err_cnt",        err_cnt[0],    m_err);
      check("ctr_datain",     ctr_datain[0], m_datain);
      check("nochk_rsp_data", rsp_data[1],   m_rsp);
      check("nochk_rsp_err",  rsp_err[1],    1'b0);
      check("nochk_err_cnt",  err_cnt[1],    8'h00);
    end
    // advance the model to what the coming edge produces
    if (!rst_n) begin
      armed = 1'b1; active = 1'b0;
      m_val = 8'h00; m_rsp = 8'h00; m_rerr = 1'b0; m_err = 0; m_datain = 8'h00;
    end else if (armed) begin
      if (active) begin
        if (k >= m_lat) begin
          if (rsp_ready) active = 1'b0;
        end else begin
          if (k + 1 == m_lat) begin
            m_rsp  = m_val + fault_off;
            m_rerr = (fault_off != 8'h00);
            if (m_rerr && m_err < 255) m_err++;
          end
          k++;
        end
      end else if (cmd_valid) begin
        m_op = cmd_op; base = m_val;
        case (cmd_op)
          2'b00:   begin m_val = cmd_arg;        m_n = 0;            m_lat = 3;       m_datain = cmd_arg; end
          2'b01:   begin m_val = base + cmd_arg; m_n = int'(cmd_arg); m_lat = m_n + 2; end
          2'b10:   begin m_val = base - cmd_arg; m_n = int'(cmd_arg); m_lat = m_n + 2; end
          default: begin m_val = base;           m_n = 0;            m_lat = 2;       end
        endcase
        active = 1'b1; k = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] arg,
                        input bit inject, input int hold,
                        input logic [7:0] lit_data, input logic lit_err,
                        input int lit_lat, input int lit_en);
    int lat, en_cycles;
    bit seen;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (inject) fault_off = 8'h01;
    lat = 1; en_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (rsp_valid[0]) begin
        seen = 1'b1;
      end else begin
        if (ctr_en[0]) en_cycles++;
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!seen) check({name, "_rsp_within_budget"}, rsp_valid[0], 1'b1);
    check({name, "_latency"},   lat,       lit_lat);
    check({name, "_en_cycles"}, en_cycles, lit_en);
    repeat (hold) begin @(posedge clk); #1; end
    check({name, "_data"},     rsp_data[0], lit_data);
    check({name, "_err"},      rsp_err[0],  lit_err);
    check({name, "_nochk_err"}, rsp_err[1], 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    fault_off = 8'h00;
    check({name, "_back_idle"}, cmd_ready[0], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
    rsp_ready = 1'b0; fault_off = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_cmd_ready", cmd_ready[0],  1'b1);
    check("reset_rsp_valid", rsp_valid[0],  1'b0);
    check("reset_rsp_data",  rsp_data[0],   8'h00);
    check("reset_err_cnt",   err_cnt[0],    8'h00);
    check("reset_busy",      busy[0],       1'b0);
    check("reset_ctr_ctrl",  {ctr_ld_en[0], ctr_en[0], ctr_updwn[0]}, 3'b000);
    check("reset_datain",    ctr_datain[0], 8'h00);
    repeat (2) begin @(posedge clk); #1; end

    //      name         op     arg    inj hold data   err lat en
    do_cmd("read0",     2'b11, 8'h00, 0,  0,   8'h00, 0,  2,  0);
    do_cmd("load_a5",   2'b00, 8'hA5, 0,  0,   8'hA5, 0,  3,  0);
    do_cmd("up3",       2'b01, 8'd3,  0,  0,   8'hA8, 0,  5,  3);
    do_cmd("load_fe",   2'b00, 8'hFE, 0,  0,   8'hFE, 0,  3,  0);
    do_cmd("up4_wrap",  2'b01, 8'd4,  0,  1,   8'h02, 0,  6,  4);
    do_cmd("load_01",   2'b00, 8'h01, 0,  0,   8'h01, 0,  3,  0);
    do_cmd("dn3_wrap",  2'b10, 8'd3,  0,  0,   8'hFE, 0,  5,  3);
    check("no_err_yet", err_cnt[0], 8'h00);
    do_cmd("load_33",   2'b00, 8'h33, 0,  0,   8'h33, 0,  3,  0);
    do_cmd("up0_hold",  2'b01, 8'd0,  0,  5,   8'h33, 0,  2,  0);
    do_cmd("load_10",   2'b00, 8'h10, 0,  0,   8'h10, 0,  3,  0);
    do_cmd("up2_fault", 2'b01, 8'd2,  1,  0,   8'h13, 1,  4,  2);
    check("fault_err_cnt",       err_cnt[0], 8'h01);
    check("fault_nochk_err_cnt", err_cnt[1], 8'h00);

    // reset during the 5th STEP cycle of UP 10
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_en_before_reset", ctr_en[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_cmd_ready", cmd_ready[0], 1'b1);
    check("abort_rsp_valid", rsp_valid[0], 1'b0);
    check("abort_en",        ctr_en[0],    1'b0);
    check("abort_err_cnt",   err_cnt[0],   8'h00);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_no_rsp",    rsp_valid[0], 1'b0);
    do_cmd("read_after_abort", 2'b11, 8'h5A, 0, 0, 8'h00, 0, 2, 0);

    repeat (2) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
